axi_4_stream_writer: RTL and testbench

AXI_4_STREAM_WRITER -- requirements
Module: axi_4_stream_writer

---
 rtl/axi_4_stream_writer.sv | 179 +++++++++++++++++
 tb/tb_axi_4_stream_writer.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_4_stream_writer.sv
// Captures a 32-bit sample stream into a FIFO and writes it to a ring buffer in memory
// as fixed-length AXI4 INCR bursts, one burst outstanding at a time.
module axi_4_stream_writer #(
    parameter int ADDR_WIDTH = 32,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  enable,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] size_bytes,
    input  logic [31:0]           s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [31:0]           m_axi_wdata,
    output logic [3:0]            m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_WIDTH-1:0] write_ptr,
    output logic                  overflow,
    output logic                  resp_error
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BEAT_W = $clog2(BURST_LEN);
    localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(4 * BURST_LEN);
    localparam logic [CNT_W-1:0]      FULL_CNT    = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]      BURST_CNT   = CNT_W'(BURST_LEN);
    localparam logic [BEAT_W-1:0]     LAST_BEAT   = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t                state_q, state_d;
    logic [31:0]           mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [ADDR_WIDTH-1:0] offset_q, offset_d, write_ptr_q, write_ptr_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d, size_q, size_d, offset_next;
    logic                  enable_q, enable_d, live_q, live_d;
    logic                  overflow_q, overflow_d, resp_error_q, resp_error_d;
    logic                  enable_rise, fifo_full, push, pop, flush;

    // live_q keeps tready low during reset and for the first cycle after release
    assign enable_rise   = enable & ~enable_q;
    assign fifo_full     = (count_q == FULL_CNT);
    assign s_axis_tready = live_q & (enable ? ~fifo_full : (state_q == IDLE));
    assign push          = s_axis_tvalid & s_axis_tready & enable;
    assign pop           = (state_q == DATA) & m_axi_wready;
    assign flush         = ~enable & (state_q == IDLE);
    assign offset_next   = offset_q + BURST_BYTES;

    assign m_axi_awaddr  = base_q + offset_q;
    assign m_axi_awlen   = 8'(BURST_LEN - 1);
    assign m_axi_awsize  = 3'b010;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awvalid = (state_q == ADDR);
    assign m_axi_wdata   = mem_q[rd_ptr_q];
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wvalid  = (state_q == DATA);
    assign m_axi_wlast   = (state_q == DATA) && (beat_q == LAST_BEAT);
    assign m_axi_bready  = (state_q == RESP);
    assign write_ptr     = write_ptr_q;
    assign overflow      = overflow_q;
    assign resp_error    = resp_error_q;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        beat_d       = beat_q;
        offset_d     = offset_q;
        write_ptr_d  = write_ptr_q;
        base_d       = base_q;
        size_d       = size_q;
        overflow_d   = overflow_q;
        resp_error_d = resp_error_q;
        enable_d     = enable;
        live_d       = 1'b1;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end

        case (state_q)
            IDLE: if (enable && count_q >= BURST_CNT) state_d = ADDR;
            ADDR: begin
                if (m_axi_awready) begin
                    state_d = DATA;
                    beat_d  = '0;
                end
            end
            DATA: begin
                if (m_axi_wready) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_q == LAST_BEAT) state_d = RESP;
                end
            end
            RESP: begin
                if (m_axi_bvalid) begin
                    offset_d    = (offset_next == size_q) ? '0 : offset_next;
                    write_ptr_d = offset_d;
                    if (m_axi_bresp != 2'b00) resp_error_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new capture session restarts the ring from its base, overriding burst bookkeeping
        if (enable_rise) begin
            base_d       = base_addr;
            size_d       = size_bytes;
            offset_d     = '0;
            write_ptr_d  = '0;
            overflow_d   = 1'b0;
            resp_error_d = 1'b0;
        end

        if (enable && s_axis_tvalid && !s_axis_tready) overflow_d = 1'b1;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            beat_q       <= '0;
            offset_q     <= '0;
            write_ptr_q  <= '0;
            base_q       <= '0;
            size_q       <= '0;
            overflow_q   <= 1'b0;
            resp_error_q <= 1'b0;
            enable_q     <= 1'b0;
            live_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            beat_q       <= beat_d;
            offset_q     <= offset_d;
            write_ptr_q  <= write_ptr_d;
            base_q       <= base_d;
            size_q       <= size_d;
            overflow_q   <= overflow_d;
            resp_error_q <= resp_error_d;
            enable_q     <= enable_d;
            live_q       <= live_d;
        end
    end

    // Sample storage needs no reset; validity is tracked by the pointers and count
    always_ff @(posedge aclk) begin
        if (push) mem_q[wr_ptr_q] <= s_axis_tdata;
    end

endmodule

// File: tb/tb_axi_4_stream_writer.sv
// Directed testbench for axi_4_stream_writer with a simple always-ready-capable AXI slave
// responder; each scenario task drives stimulus and checks its own expected values.
module tb_axi_4_stream_writer;

    localparam int AW = 32;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b1;
    logic          enable = 1'b0;
    logic [AW-1:0] base_addr = BASE;
    logic [AW-1:0] size_bytes = 32'h80;
    logic [31:0]   s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [AW-1:0] m_axi_awaddr;
    logic [7:0]    m_axi_awlen;
    logic [2:0]    m_axi_awsize;
    logic [1:0]    m_axi_awburst;
    logic          m_axi_awvalid;
    logic          m_axi_awready = 1'b1;
    logic [31:0]   m_axi_wdata;
    logic [3:0]    m_axi_wstrb;
    logic          m_axi_wlast;
    logic          m_axi_wvalid;
    logic          m_axi_wready = 1'b1;
    logic [1:0]    m_axi_bresp = 2'b00;
    logic          m_axi_bvalid = 1'b0;
    logic          m_axi_bready;
    logic [AW-1:0] write_ptr;
    logic          overflow;
    logic          resp_error;

    int n_cmp = 0;
    int n_fail = 0;

    // Slave responder knobs and monitor records
    int          aw_stall = 0;
    bit          w_block = 0;
    bit          w_pat_en = 0;
    logic [15:0] w_pat = 16'b1011_0110_1101_0011;
    int          w_idx = 0;
    bit          err_next = 0;
    bit          b_pending = 0;
    bit          b_retire = 0;
    int          b_count = 0;
    int          both_cnt = 0;
    logic [31:0] aw_q[$];
    logic [31:0] aw_seen_q[$];
    logic [31:0] w_q[$];
    bit          wl_q[$];

    always #5 aclk = ~aclk;

    axi_4_stream_writer #(.ADDR_WIDTH(AW), .BURST_LEN(16), .FIFO_DEPTH(32)) dut (
        .aclk(aclk), .aresetn(aresetn), .enable(enable),
        .base_addr(base_addr), .size_bytes(size_bytes),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .write_ptr(write_ptr), .overflow(overflow), .resp_error(resp_error)
    );

    // Slave inputs change on the falling edge; handshakes seen here complete at the next rising edge
    always @(negedge aclk) begin
        if (!aresetn) begin
            b_pending = 0;
            b_retire = 0;
            m_axi_bvalid = 1'b0;
        end else begin
            if (b_retire) begin
                m_axi_bvalid = 1'b0;
                b_retire = 0;
                b_count++;
            end
            if (b_pending && !m_axi_bvalid) begin
                m_axi_bvalid = 1'b1;
                m_axi_bresp = err_next ? 2'b10 : 2'b00;
                err_next = 0;
                b_pending = 0;
            end
            if (m_axi_awvalid && aw_stall > 0) begin
                m_axi_awready = 1'b0;
                aw_stall--;
            end else begin
                m_axi_awready = 1'b1;
            end
            if (w_block) m_axi_wready = 1'b0;
            else if (w_pat_en) begin
                m_axi_wready = w_pat[w_idx % 16];
                w_idx++;
            end else m_axi_wready = 1'b1;
            if (m_axi_awvalid) aw_seen_q.push_back(m_axi_awaddr);
            if (m_axi_awvalid && m_axi_awready) aw_q.push_back(m_axi_awaddr);
            if (m_axi_wvalid && m_axi_wready) begin
                w_q.push_back(m_axi_wdata);
                wl_q.push_back(m_axi_wlast);
                if (m_axi_wlast) b_pending = 1;
            end
            if (m_axi_bvalid && m_axi_bready) b_retire = 1;
            if (m_axi_awvalid && m_axi_wvalid) both_cnt++;
        end
    end

    task automatic clear_records();
        aw_q.delete();
        aw_seen_q.delete();
        w_q.delete();
        wl_q.delete();
        b_count = 0;
    endtask

    // Drop enable long enough to flush, then raise it to start a fresh session
    task automatic restart();
        @(negedge aclk);
        enable = 1'b0;
        repeat (3) @(negedge aclk);
        clear_records();
        enable = 1'b1;
        @(negedge aclk);
    endtask

    task automatic send_samples(input int n, input logic [31:0] first);
        int sent = 0;
        int guard = 0;
        while (sent < n && guard < 2000) begin
            @(negedge aclk);
            s_axis_tdata = first + sent;
            s_axis_tvalid = 1'b1;
            #1;
            if (s_axis_tready) sent++;
            guard++;
        end
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        n_cmp++;
        if (sent !== n) begin
            n_fail++;
            $display("[TB] FAIL send_samples: accepted %0d required %0d", sent, n);
        end
    endtask

    task automatic wait_bursts(input int target);
        int guard = 0;
        while (b_count < target && guard < 3000) begin
            @(negedge aclk);
            guard++;
        end
        n_cmp++;
        if (b_count < target) begin
            n_fail++;
            $display("[TB] FAIL burst_timeout: completed %0d required %0d", b_count, target);
        end
    endtask

    task automatic test_reset();
        #1 aresetn = 1'b0;
        #2;
        n_cmp++;
        if ({s_axis_tready, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready} !== 5'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_ctrl: got %b required 00000",
                     {s_axis_tready, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready});
        end
        n_cmp++;
        if (write_ptr !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_write_ptr: got %h required 00000000", write_ptr);
        end
        n_cmp++;
        if ({overflow, resp_error} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL reset_flags: got %b required 00", {overflow, resp_error});
        end
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);
        #1;
        n_cmp++;
        if (s_axis_tready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL idle_tready: got %b required 1", s_axis_tready);
        end
    endtask

    task automatic test_single_burst();
        restart();
        n_cmp++;
        if (write_ptr !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL session_write_ptr: got %h required 00000000", write_ptr);
        end
        send_samples(16, 32'd0);
        wait_bursts(1);
        n_cmp++;
        if (aw_q.size() !== 1 || aw_q[0] !== BASE) begin
            n_fail++;
            $display("[TB] FAIL single_aw: got %0d bursts first %h required 1 at %h", aw_q.size(), aw_q[0], BASE);
        end
        n_cmp++;
        if ({m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_wstrb} !== {8'd15, 3'b010, 2'b01, 4'hF}) begin
            n_fail++;
            $display("[TB] FAIL aw_const: got len %0d size %b burst %b strb %h required 15 010 01 f",
                     m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_wstrb);
        end
        n_cmp++;
        if (w_q.size() !== 16) begin
            n_fail++;
            $display("[TB] FAIL single_beats: got %0d required 16", w_q.size());
        end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (w_q[i] !== 32'(i) || wl_q[i] !== (i == 15)) begin
                n_fail++;
                $display("[TB] FAIL single_beat%0d: got data %h last %b required %h last %b",
                         i, w_q[i], wl_q[i], i, (i == 15));
            end
        end
        n_cmp++;
        if (write_ptr !== 32'h40) begin
            n_fail++;
            $display("[TB] FAIL single_write_ptr: got %h required 00000040", write_ptr);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_addr [3];
        exp_addr[0] = BASE;
        exp_addr[1] = BASE + 32'h40;
        exp_addr[2] = BASE;
        restart();
        send_samples(48, 32'd0);
        wait_bursts(3);
        n_cmp++;
        if (aw_q.size() !== 3) begin
            n_fail++;
            $display("[TB] FAIL wrap_count: got %0d required 3", aw_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (aw_q[i] !== exp_addr[i]) begin
                n_fail++;
                $display("[TB] FAIL wrap_addr%0d: got %h required %h", i, aw_q[i], exp_addr[i]);
            end
        end
        n_cmp++;
        if (w_q.size() !== 48 || w_q[47] !== 32'd47 || w_q[20] !== 32'd20) begin
            n_fail++;
            $display("[TB] FAIL wrap_data: got %0d beats last %h required 48 ending 0000002f", w_q.size(), w_q[47]);
        end
        n_cmp++;
        if (write_ptr !== 32'h40) begin
            n_fail++;
            $display("[TB] FAIL wrap_write_ptr: got %h required 00000040", write_ptr);
        end
    endtask

    task automatic test_stalls();
        int moved = 0;
        restart();
        aw_stall = 10;
        w_idx = 0;
        w_pat_en = 1;
        send_samples(16, 32'h100);
        wait_bursts(1);
        w_pat_en = 0;
        foreach (aw_seen_q[i]) if (aw_seen_q[i] !== BASE) moved++;
        n_cmp++;
        if (aw_seen_q.size() !== 11 || moved !== 0) begin
            n_fail++;
            $display("[TB] FAIL aw_stall: got %0d valid cycles %0d changed required 11 and 0", aw_seen_q.size(), moved);
        end
        n_cmp++;
        if (aw_q.size() !== 1 || w_q.size() !== 16) begin
            n_fail++;
            $display("[TB] FAIL stall_counts: got %0d aw %0d beats required 1 and 16", aw_q.size(), w_q.size());
        end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (w_q[i] !== 32'h100 + 32'(i)) begin
                n_fail++;
                $display("[TB] FAIL stall_beat%0d: got %h required %h", i, w_q[i], 32'h100 + 32'(i));
            end
        end
    endtask

    task automatic test_overflow();
        int k = 0;
        restart();
        w_block = 1;
        for (int c = 0; c < 60; c++) begin
            @(negedge aclk);
            s_axis_tdata = 32'(k);
            s_axis_tvalid = 1'b1;
            #1;
            if (s_axis_tready) k++;
        end
        n_cmp++;
        if (k !== 32) begin
            n_fail++;
            $display("[TB] FAIL fifo_capacity: got %0d required 32", k);
        end
        n_cmp++;
        if ({s_axis_tready, overflow} !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL full_flags: got tready %b overflow %b required 0 1", s_axis_tready, overflow);
        end
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        w_block = 0;
        wait_bursts(2);
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL overflow_sticky: got %b required 1", overflow);
        end
        n_cmp++;
        if (w_q.size() !== 32 || w_q[0] !== 32'd0 || w_q[31] !== 32'd31 || wl_q[15] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL overflow_data: got %0d beats first %h last %h required 32 beats 0..1f",
                     w_q.size(), w_q[0], w_q[31]);
        end
        @(negedge aclk);
        enable = 1'b0;
        repeat (3) @(negedge aclk);
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL overflow_disabled: got %b required 1", overflow);
        end
        enable = 1'b1;
        @(negedge aclk);
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL overflow_clear: got %b required 0", overflow);
        end
    endtask

    task automatic test_resp_error();
        restart();
        err_next = 1;
        send_samples(16, 32'h200);
        wait_bursts(1);
        n_cmp++;
        if ({resp_error, write_ptr} !== {1'b1, 32'h40}) begin
            n_fail++;
            $display("[TB] FAIL resp_err_first: got err %b ptr %h required 1 00000040", resp_error, write_ptr);
        end
        send_samples(16, 32'h300);
        wait_bursts(2);
        n_cmp++;
        if (aw_q.size() !== 2 || aw_q[1] !== BASE + 32'h40) begin
            n_fail++;
            $display("[TB] FAIL resp_err_next: got %0d bursts second %h required 2 at %h", aw_q.size(), aw_q[1], BASE + 32'h40);
        end
        n_cmp++;
        if ({resp_error, write_ptr} !== {1'b1, 32'h0}) begin
            n_fail++;
            $display("[TB] FAIL resp_err_sticky: got err %b ptr %h required 1 00000000", resp_error, write_ptr);
        end
    endtask

    task automatic test_reset_mid_burst();
        int guard = 0;
        int active = 0;
        restart();
        send_samples(16, 32'd0);
        while (!(m_axi_wvalid && m_axi_wdata == 32'd5) && guard < 200) begin
            @(negedge aclk);
            guard++;
        end
        n_cmp++;
        if (!(m_axi_wvalid && m_axi_wdata == 32'd5)) begin
            n_fail++;
            $display("[TB] FAIL beat5_timeout: got wvalid %b wdata %h required 1 00000005", m_axi_wvalid, m_axi_wdata);
        end
        #2 aresetn = 1'b0;
        #1;
        n_cmp++;
        if ({s_axis_tready, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready} !== 5'b0) begin
            n_fail++;
            $display("[TB] FAIL async_reset_ctrl: got %b required 00000",
                     {s_axis_tready, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready});
        end
        n_cmp++;
        if ({write_ptr, overflow, resp_error} !== {32'h0, 2'b00}) begin
            n_fail++;
            $display("[TB] FAIL async_reset_state: got ptr %h flags %b required 00000000 00", write_ptr, {overflow, resp_error});
        end
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        clear_records();
        repeat (10) begin
            @(negedge aclk);
            if (m_axi_awvalid || m_axi_wvalid || m_axi_bready) active++;
        end
        n_cmp++;
        if (active !== 0) begin
            n_fail++;
            $display("[TB] FAIL no_resume: got %0d busy cycles required 0", active);
        end
        send_samples(16, 32'd100);
        wait_bursts(1);
        n_cmp++;
        if (aw_q.size() !== 1 || aw_q[0] !== BASE || w_q.size() !== 16 || w_q[0] !== 32'd100) begin
            n_fail++;
            $display("[TB] FAIL post_reset_burst: got %0d aw at %h first %h required 1 at %h first 00000064",
                     aw_q.size(), aw_q[0], w_q[0], BASE);
        end
    endtask

    task automatic test_exclusive_channels();
        n_cmp++;
        if (both_cnt !== 0) begin
            n_fail++;
            $display("[TB] FAIL aw_w_overlap: got %0d cycles required 0", both_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_wrap();
        test_stalls();
        test_overflow();
        test_resp_error();
        test_reset_mid_burst();
        test_exclusive_channels();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
